// File: rtl/cache_arbiter.sv
// N-to-1 round-robin arbiter from upstream cache ports onto one shared downstream port.
// Define FIXED_PRIORITY_EN to make arbitration always favour the lowest-index requester.
module cache_arbiter #(
  parameter int N      = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*ADDR_W-1:0] up_addr,
  input  logic [N*DATA_W-1:0] up_wdata,
  input  logic [N-1:0]        up_read_en,
  input  logic [N-1:0]        up_write_en,
  output logic [N*DATA_W-1:0] up_rdata,
  output logic [N-1:0]        up_grant,
  output logic [N-1:0]        up_stall,
  output logic [ADDR_W-1:0]   ds_addr,
  output logic [DATA_W-1:0]   ds_wdata,
  output logic                ds_read_en,
  output logic                ds_write_en,
  input  logic [DATA_W-1:0]   ds_rdata,
  input  logic                ds_stall
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  owner, sel;
  logic [N-1:0]      req, cand, ack;
  logic              op_write;
  logic              first_wait;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  assign req      = up_read_en | up_write_en;
  // The port acked last cycle is masked so its held request is not reissued.
  assign cand     = req & ~ack;
  assign up_stall = cand;

  assign own_addr  = up_addr[int'(owner)*ADDR_W +: ADDR_W];
  assign own_wdata = up_wdata[int'(owner)*DATA_W +: DATA_W];

`ifdef FIXED_PRIORITY_EN
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--)
      if (cand[i]) sel = IDX_W'(i);
  end
`else
  logic [IDX_W-1:0] last;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    int j;
    sel = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(last) + 1 + k;
      if (j >= N) j -= N;
      if (cand[j]) sel = IDX_W'(j);
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < N; i++)
      up_grant[i] = (state != S_IDLE) && (owner == IDX_W'(i));
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nxt   = state;
    ds_addr     = '0;
    ds_wdata    = '0;
    ds_read_en  = 1'b0;
    ds_write_en = 1'b0;
    case (state)
      S_IDLE: if (|cand) state_nxt = S_ISSUE;
      S_ISSUE: begin
        ds_addr     = own_addr;
        ds_wdata    = own_wdata;
        ds_write_en = op_write;
        ds_read_en  = ~op_write;
        if (!ds_stall) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        ds_addr  = own_addr;
        ds_wdata = own_wdata;
        // Downstream only raises stall the cycle after acceptance.
        if (!first_wait && !ds_stall) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The operation type is latched at selection so a dropped request still completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      op_write   <= 1'b0;
      first_wait <= 1'b0;
      ack        <= '0;
      // NOTE: the read-data registers are architecturally visible, so they are reset too.
      up_rdata   <= '0;
`ifndef FIXED_PRIORITY_EN
      last       <= IDX_W'(N - 1);
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      ack   <= '0;
      case (state)
        S_IDLE: begin
          if (|cand) begin
            owner    <= sel;
            op_write <= up_write_en[sel];
          end
        end
        S_ISSUE: first_wait <= 1'b1;
        S_WAIT: begin
          first_wait <= 1'b0;
          if (!first_wait && !ds_stall) begin
            if (!op_write) up_rdata[int'(owner)*DATA_W +: DATA_W] <= ds_rdata;
            ack[owner] <= 1'b1;
`ifndef FIXED_PRIORITY_EN
            last       <= owner;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with a latency-programmable downstream model.
module tb_cache_arbiter;
  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*AW-1:0] up_addr;
  logic [N*DW-1:0] up_wdata;
  logic [N-1:0]    up_read_en, up_write_en;
  logic [N*DW-1:0] up_rdata;
  logic [N-1:0]    up_grant, up_stall;
  logic [AW-1:0]   ds_addr;
  logic [DW-1:0]   ds_wdata, ds_rdata;
  logic            ds_read_en, ds_write_en;
  logic            ds_stall = 1'b0;

  logic [DW-1:0]   fixed_rdata;
  logic            use_addr_data;
  logic [AW-1:0]   salt;
  int              lat_k;
  logic            force_busy = 1'b0;
  int              busy_cnt = 0;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .up_addr(up_addr), .up_wdata(up_wdata),
    .up_read_en(up_read_en), .up_write_en(up_write_en),
    .up_rdata(up_rdata), .up_grant(up_grant), .up_stall(up_stall),
    .ds_addr(ds_addr), .ds_wdata(ds_wdata),
    .ds_read_en(ds_read_en), .ds_write_en(ds_write_en),
    .ds_rdata(ds_rdata), .ds_stall(ds_stall)
  );

  always #5 clk = ~clk;

  assign ds_rdata = use_addr_data ? {8{ds_addr ^ salt}} : fixed_rdata;

  // Downstream: accepts when not busy, idles one cycle, then stalls lat_k cycles.
  always @(negedge clk) begin
    if (!rst) begin
      ds_stall = 1'b0;
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      ds_stall = 1'b1;
      busy_cnt--;
    end else begin
      ds_stall = force_busy;
      if ((ds_read_en || ds_write_en) && !force_busy) busy_cnt = lat_k;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs until the port's stall drops; lat counts edges after the request edge.
  task automatic serve(input int port, output int lat, output int rd_cnt, output int wr_cnt,
                       output logic [AW-1:0] addr, output logic [DW-1:0] wdata);
    int n;
    bit done;
    n = 0; rd_cnt = 0; wr_cnt = 0; addr = '0; wdata = '0; done = 1'b0;
    while (!done && n < 200) begin
      tick();
      n++;
      if (ds_read_en) begin rd_cnt++; addr = ds_addr; end
      if (ds_write_en) begin wr_cnt++; addr = ds_addr; wdata = ds_wdata; end
      if (!up_stall[port]) done = 1'b1;
    end
    if (!done) check("serve_done", DW'(up_stall[port]), '0);
    lat = n - 1;
  endtask

  initial begin
    int lat, rd_cnt, wr_cnt, cnt;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd0;
    logic [N-1:0] prev;
    int order[4];
    int exp_order[4];

    exp_order = '{0, 1, 0, 1};
    up_addr = '0; up_wdata = '0; up_read_en = '0; up_write_en = '0;
    fixed_rdata = {64{8'hAA}}; use_addr_data = 1'b0; salt = '0; lat_k = 9;

    // Reset held with port 0 requesting.
    up_addr[63:0] = 64'h40;
    up_read_en    = 2'b01;
    repeat (2) tick();
    check("rst_grant", DW'(up_grant), DW'(2'b00));
    check("rst_stall", DW'(up_stall), DW'(2'b01));
    check("rst_ds_en", DW'({ds_read_en, ds_write_en}), '0);
    check("rst_ds_addr", DW'(ds_addr), '0);
    check("rst_rdata0", up_rdata[511:0], '0);
    check("rst_rdata1", up_rdata[1023:512], '0);

    // Release: port 0 read with K=9.
    rst = 1'b1;
    serve(0, lat, rd_cnt, wr_cnt, a, wd);
    check("rd_latency", DW'(lat), DW'(11));
    check("rd_strobes", DW'(rd_cnt), DW'(1));
    check("rd_no_write", DW'(wr_cnt), DW'(0));
    check("rd_addr", DW'(a), DW'(64'h40));
    check("rd_data", up_rdata[511:0], {64{8'hAA}});
    up_read_en = '0;
    tick();

    // Port 1 write.
    up_addr[127:64]    = 64'h80;
    up_wdata[1023:512] = 512'h1234;
    up_write_en        = 2'b10;
    serve(1, lat, rd_cnt, wr_cnt, a, wd);
    check("wr_latency", DW'(lat), DW'(11));
    check("wr_strobes", DW'(wr_cnt), DW'(1));
    check("wr_no_read", DW'(rd_cnt), DW'(0));
    check("wr_addr", DW'(a), DW'(64'h80));
    check("wr_data", wd, 512'h1234);
    check("wr_rdata1_kept", up_rdata[1023:512], '0);
    up_write_en = '0;
    tick();

    // Both ports held: service alternates.
    lat_k = 2; use_addr_data = 1'b1; salt = 64'h1111;
    up_addr[63:0] = 64'h100; up_addr[127:64] = 64'h200;
    up_read_en = 2'b11;
    prev = '0; cnt = 0;
    for (int i = 0; i < 100 && cnt < 4; i++) begin
      tick();
      if (up_grant != '0 && prev == '0) begin
        order[cnt] = up_grant[1] ? 1 : 0;
        cnt++;
      end
      prev = up_grant;
    end
    check("alt_count", DW'(cnt), DW'(4));
    for (int i = 0; i < 4; i++) check($sformatf("alt_order%0d", i), DW'(order[i]), DW'(exp_order[i]));
    check("alt_rdata0", up_rdata[511:0], {8{64'h100 ^ 64'h1111}});
    check("alt_rdata1", up_rdata[1023:512], {8{64'h200 ^ 64'h1111}});

    // Drop requests mid-transaction: port 1 must still complete and capture.
    salt = 64'h2222;
    up_read_en = '0;
    for (int i = 0; i < 50 && up_grant != '0; i++) tick();
    check("drop_grant", DW'(up_grant), '0);
    check("drop_rdata1", up_rdata[1023:512], {8{64'h200 ^ 64'h2222}});
    tick();

    // Serve port 0 alone, then both at once: priority decides.
    up_read_en = 2'b01;
    serve(0, lat, rd_cnt, wr_cnt, a, wd);
    check("k2_latency", DW'(lat), DW'(4));
    up_read_en = '0;
    tick();
    up_read_en = 2'b11;
    tick();
`ifdef FIXED_PRIORITY_EN
    check("prio_first", DW'(up_grant), DW'(2'b01));
`else
    check("prio_first", DW'(up_grant), DW'(2'b10));
`endif
    up_read_en = '0;
    for (int i = 0; i < 50 && up_grant != '0; i++) tick();
    tick();

    // Downstream busy during ISSUE.
    salt = 64'h3333;
    up_addr[63:0] = 64'h40;
    force_busy = 1'b1;
    up_read_en = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("busy_rd_en%0d", i), DW'(ds_read_en), DW'(1));
      check($sformatf("busy_grant%0d", i), DW'(up_grant), DW'(2'b01));
    end
    force_busy = 1'b0;
    tick();
    check("busy_accepted", DW'(ds_read_en), DW'(0));
    check("busy_grant_wait", DW'(up_grant), DW'(2'b01));
    for (int i = 0; i < 50 && up_stall[0]; i++) tick();
    exp_rd0 = {8{64'h40 ^ 64'h3333}};
    check("busy_rdata0", up_rdata[511:0], exp_rd0);
    up_read_en = '0;
    tick();

    // Both enables on port 0: write wins.
    up_addr[63:0]  = 64'h300;
    up_wdata[511:0] = 512'h55;
    up_read_en  = 2'b01;
    up_write_en = 2'b01;
    serve(0, lat, rd_cnt, wr_cnt, a, wd);
    check("both_wr", DW'(wr_cnt), DW'(1));
    check("both_no_rd", DW'(rd_cnt), DW'(0));
    check("both_addr", DW'(a), DW'(64'h300));
    check("both_wdata", wd, 512'h55);
    check("both_rdata0_kept", up_rdata[511:0], exp_rd0);
    up_read_en = '0; up_write_en = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
